// File: rtl/armleocpu_ptw_if.sv
// Signal bundle between the page-table walker, its TLB client and the Avalon-MM
// memory port. The master modport is the walker side.
interface armleocpu_ptw_if;
    // Handshakes:
    // - TLB side: a walk starts in the cycle where resolve_request and resolve_ack are both 1.
    //   The walker answers once with a resolve_done pulse, carrying the fault flags, metadata and address.
    // - Memory side: avl_read and avl_address stay constant until a cycle with avl_waitrequest low.
    //   That cycle accepts the read and also returns avl_readdata and avl_response.
    logic [21:0] satp_ppn;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic        resolve_ack;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [7:0]  resolve_metadata_output;
    logic [21:0] resolve_physical_address;
    logic [33:0] avl_address;
    logic        avl_read;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic [1:0]  avl_response;

    modport master (
        input  satp_ppn, resolve_request, resolve_virtual_address,
        input  avl_waitrequest, avl_readdata, avl_response,
        output resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
        output resolve_metadata_output, resolve_physical_address,
        output avl_address, avl_read
    );

    modport slave (
        output satp_ppn, resolve_request, resolve_virtual_address,
        output avl_waitrequest, avl_readdata, avl_response,
        input  resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
        input  resolve_metadata_output, resolve_physical_address,
        input  avl_address, avl_read
    );
endinterface

// File: rtl/armleocpu_ptw.sv
// Sv32 two-level hardware page-table walker. It resolves one TLB miss at a time.
// The walk ends in a leaf PTE, a page fault or a memory access fault.
module armleocpu_ptw (
    input  logic                  clk,
    input  logic                  rst_n,
    armleocpu_ptw_if.master       bus,
    output logic                  dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t      state;
    logic        level;
    logic [21:0] table_base;
    logic [19:0] vpn;

    logic        done_r;
    logic        pagefault_r;
    logic        accessfault_r;
    logic [7:0]  metadata_r;
    logic [21:0] phys_r;

    logic [31:0] pte;
    logic        pte_invalid;
    logic        pte_leaf;
    logic        pte_misaligned;
    logic        beat;
    logic        unused_pte_rsw;

    assign pte            = bus.avl_readdata;
    // Invalid means V clear, or a W-without-R encoding, which is reserved.
    assign pte_invalid    = !pte[0] || (pte[2] && !pte[1]);
    assign pte_leaf       = pte[1] || pte[3];
    assign pte_misaligned = (pte[19:10] != 10'd0);
    assign unused_pte_rsw = ^pte[9:8];
    assign beat           = (state == READ) && !bus.avl_waitrequest;

    assign bus.resolve_ack              = (state == IDLE) && bus.resolve_request;
    assign bus.avl_read                 = (state == READ);
    assign bus.avl_address              = {table_base, (level ? vpn[19:10] : vpn[9:0]), 2'b00};
    assign bus.resolve_done             = done_r;
    assign bus.resolve_pagefault        = pagefault_r;
    assign bus.resolve_accessfault      = accessfault_r;
    assign bus.resolve_metadata_output  = metadata_r;
    assign bus.resolve_physical_address = phys_r;
    assign dbg_state                    = (state == READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            level         <= 1'b1;
            table_base    <= 22'd0;
            vpn           <= 20'd0;
            done_r        <= 1'b0;
            pagefault_r   <= 1'b0;
            accessfault_r <= 1'b0;
            metadata_r    <= 8'd0;
            phys_r        <= 22'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.resolve_request) begin
                        vpn        <= bus.resolve_virtual_address;
                        table_base <= bus.satp_ppn;
                        level      <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (beat) begin
                        if (bus.avl_response != 2'b00) begin
                            done_r        <= 1'b1;
                            accessfault_r <= 1'b1;
                            pagefault_r   <= 1'b0;
                            state         <= IDLE;
                        end else if (pte_invalid) begin
                            done_r        <= 1'b1;
                            accessfault_r <= 1'b0;
                            pagefault_r   <= 1'b1;
                            state         <= IDLE;
                        end else if (pte_leaf) begin
                            done_r        <= 1'b1;
                            accessfault_r <= 1'b0;
                            state         <= IDLE;
                            if (level && pte_misaligned) begin
                                pagefault_r <= 1'b1;
                            end else begin
                                pagefault_r <= 1'b0;
                                metadata_r  <= pte[7:0];
                                // A megapage maps VPN0 straight through to the low PPN bits.
                                phys_r      <= level ? {pte[31:20], vpn[9:0]} : pte[31:10];
                            end
                        end else if (level) begin
                            table_base <= pte[31:10];
                            level      <= 1'b0;
                        end else begin
                            // A pointer found at the last level has nowhere left to go.
                            done_r        <= 1'b1;
                            accessfault_r <= 1'b0;
                            pagefault_r   <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
